// File: rtl/sram64x32_rmw_ctrl.sv
// Load/store controller for the 64x32 single-port SRAM wrapper built from four 64x8 macros.
// Byte-masked stores run as read-modify-write because the wrapper has no write mask.
module sram64x32_rmw_ctrl #(
  parameter int AW = 6,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [DW/8-1:0] req_be,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW-1:0]   req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_rdata,
  output logic            mem_ce,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_idat,
  input  logic [DW-1:0]   mem_odat
);

  localparam int NB = DW / 8;

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            we_q, we_d;
  logic [NB-1:0]   be_q, be_d;
  logic [DW-1:0]   data_q, data_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            req_ready_q, req_ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            mem_ce_q, mem_ce_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_idat_q, mem_idat_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    be_d    = be_q;
    data_d  = data_q;
    rdata_d = rdata_q;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          addr_d = req_addr;
          we_d   = req_we;
          be_d   = req_be;
          data_d = req_wdata;
          if (!req_we) begin
            state_d = RD;
          end else begin
            rdata_d = '0;
            if (req_be == {NB{1'b1}})
              state_d = WR;
            else if (req_be == '0)
              state_d = RESP;
            else
              state_d = RD;
          end
        end
      end
      RD: state_d = CAP;
      CAP: begin
        if (!we_q) begin
          rdata_d = mem_odat;
          state_d = RESP;
        end else begin
          // Merge: enabled lanes keep the store data, the rest come from the old word.
          for (int i = 0; i < NB; i++)
            data_d[8*i +: 8] = be_q[i] ? data_q[8*i +: 8] : mem_odat[8*i +: 8];
          state_d = WR;
        end
      end
      WR: state_d = RESP;
      RESP: begin
        if (rsp_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Every output is a flop loaded from the upcoming state, so nothing is combinational.
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    mem_ce_d    = !((state_d == RD) || (state_d == WR));
    mem_we_d    = (state_d == WR);
    mem_addr_d  = ((state_d == RD) || (state_d == WR)) ? addr_d : mem_addr_q;
    mem_idat_d  = (state_d == WR) ? data_d : mem_idat_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      be_q        <= '0;
      data_q      <= '0;
      rdata_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      mem_ce_q    <= 1'b1;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_idat_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      be_q        <= be_d;
      data_q      <= data_d;
      rdata_q     <= rdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      mem_ce_q    <= mem_ce_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_idat_q  <= mem_idat_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign mem_ce    = mem_ce_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_idat  = mem_idat_q;

endmodule

// File: tb/tb_sram64x32_rmw_ctrl.sv
// Directed bench for sram64x32_rmw_ctrl with a behavioural 64x32 SRAM and a memory-cycle monitor.
module tb_sram64x32_rmw_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [3:0]  req_be;
  logic [5:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        mem_ce;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_idat;
  logic [31:0] mem_odat;

  int checks;
  int passes;

  logic [31:0] sram [64];
  int cyc;
  int rd_cnt;
  int wr_cnt;
  int rd_cyc;
  int wr_cyc;
  logic [5:0]  last_wr_addr;
  logic [31:0] last_wr_idat;

  sram64x32_rmw_ctrl #(.AW(6), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_be(req_be),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_idat(mem_idat),
    .mem_odat(mem_odat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wrapper model: active-low chip enable, read data appears the cycle after the access edge.
  always @(posedge clk) begin
    if (!mem_ce) begin
      if (mem_we) sram[mem_addr] <= mem_idat;
      else        mem_odat <= sram[mem_addr];
    end
  end

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && !mem_ce) begin
      if (mem_we) begin
        wr_cnt       <= wr_cnt + 1;
        wr_cyc       <= cyc;
        last_wr_addr <= mem_addr;
        last_wr_idat <= mem_idat;
      end else begin
        rd_cnt <= rd_cnt + 1;
        rd_cyc <= cyc;
      end
    end
  end

  // Waits for req_ready, then presents one request; returns 1 time unit after the accepting edge.
  task automatic send_req(input logic we, input logic [3:0] be, input logic [5:0] addr,
                          input logic [31:0] wdata);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!req_ready) $display("[TB] FAIL req_ready_timeout: req_ready=%0b required 1", req_ready);
    else passes++;
    req_valid = 1'b1;
    req_we    = we;
    req_be    = be;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Counts edges from the accept edge until rsp_valid is seen (bounded).
  task automatic wait_rsp(output int edges);
    edges = 0;
    while (!rsp_valid && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic finish_rsp();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int rd0, wr0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) $display("[TB] FAIL reset_req_ready: got %0b want 1", req_ready); else passes++;
    checks++; if (rsp_valid !== 1'b0) $display("[TB] FAIL reset_rsp_valid: got %0b want 0", rsp_valid); else passes++;
    checks++; if (mem_ce !== 1'b1) $display("[TB] FAIL reset_mem_ce: got %0b want 1", mem_ce); else passes++;
    checks++; if (mem_we !== 1'b0) $display("[TB] FAIL reset_mem_we: got %0b want 0", mem_we); else passes++;
    checks++; if (mem_addr !== 6'h00) $display("[TB] FAIL reset_mem_addr: got %h want 00", mem_addr); else passes++;
    checks++; if (rsp_rdata !== 32'h0) $display("[TB] FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); else passes++;
    rd0 = rd_cnt; wr0 = wr_cnt;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if ((rd_cnt - rd0) + (wr_cnt - wr0) !== 0)
      $display("[TB] FAIL idle_mem_ce: accesses=%0d want 0", (rd_cnt - rd0) + (wr_cnt - wr0));
    else passes++;
  endtask

  task automatic test_full_store_load();
    int rd0, wr0, n;
    rd0 = rd_cnt; wr0 = wr_cnt;
    send_req(1'b1, 4'hF, 6'h05, 32'hDEADBEEF);
    wait_rsp(n);
    checks++; if (n !== 1) $display("[TB] FAIL store_latency: got %0d edges want 1", n); else passes++;
    checks++; if (rsp_rdata !== 32'h0) $display("[TB] FAIL store_rdata: got %h want 0", rsp_rdata); else passes++;
    finish_rsp();
    checks++; if (wr_cnt - wr0 !== 1) $display("[TB] FAIL store_writes: got %0d want 1", wr_cnt - wr0); else passes++;
    checks++; if (rd_cnt - rd0 !== 0) $display("[TB] FAIL store_reads: got %0d want 0", rd_cnt - rd0); else passes++;
    checks++; if (last_wr_addr !== 6'h05) $display("[TB] FAIL store_addr: got %h want 05", last_wr_addr); else passes++;
    checks++; if (last_wr_idat !== 32'hDEADBEEF) $display("[TB] FAIL store_idat: got %h want deadbeef", last_wr_idat); else passes++;

    rd0 = rd_cnt; wr0 = wr_cnt;
    send_req(1'b0, 4'h0, 6'h05, 32'h0);
    wait_rsp(n);
    checks++; if (n !== 2) $display("[TB] FAIL load_latency: got %0d edges want 2", n); else passes++;
    checks++; if (rsp_rdata !== 32'hDEADBEEF) $display("[TB] FAIL load_rdata: got %h want deadbeef", rsp_rdata); else passes++;
    finish_rsp();
    checks++; if (rd_cnt - rd0 !== 1) $display("[TB] FAIL load_reads: got %0d want 1", rd_cnt - rd0); else passes++;
    checks++; if (wr_cnt - wr0 !== 0) $display("[TB] FAIL load_writes: got %0d want 0", wr_cnt - wr0); else passes++;
  endtask

  task automatic test_partial_rmw();
    int rd0, wr0, n;
    send_req(1'b1, 4'hF, 6'h3F, 32'h11223344);
    wait_rsp(n);
    finish_rsp();
    rd0 = rd_cnt; wr0 = wr_cnt;
    send_req(1'b1, 4'b0101, 6'h3F, 32'hAABBCCDD);
    wait_rsp(n);
    checks++; if (n !== 3) $display("[TB] FAIL rmw_latency: got %0d edges want 3", n); else passes++;
    finish_rsp();
    checks++; if (rd_cnt - rd0 !== 1) $display("[TB] FAIL rmw_reads: got %0d want 1", rd_cnt - rd0); else passes++;
    checks++; if (wr_cnt - wr0 !== 1) $display("[TB] FAIL rmw_writes: got %0d want 1", wr_cnt - wr0); else passes++;
    checks++; if (wr_cyc - rd_cyc !== 2) $display("[TB] FAIL rmw_order: write-read gap %0d want 2", wr_cyc - rd_cyc); else passes++;
    checks++; if (last_wr_idat !== 32'h11BB33DD) $display("[TB] FAIL rmw_idat: got %h want 11bb33dd", last_wr_idat); else passes++;
    checks++; if (last_wr_addr !== 6'h3F) $display("[TB] FAIL rmw_addr: got %h want 3f", last_wr_addr); else passes++;
    send_req(1'b0, 4'h0, 6'h3F, 32'h0);
    wait_rsp(n);
    checks++; if (rsp_rdata !== 32'h11BB33DD) $display("[TB] FAIL rmw_readback: got %h want 11bb33dd", rsp_rdata); else passes++;
    finish_rsp();
  endtask

  task automatic test_zero_mask_backpressure();
    int rd0, wr0, n;
    logic [31:0] held;
    rd0 = rd_cnt; wr0 = wr_cnt;
    send_req(1'b1, 4'h0, 6'h0A, 32'h12345678);
    wait_rsp(n);
    checks++; if (n !== 0) $display("[TB] FAIL zmask_latency: got %0d edges want 0", n); else passes++;
    checks++; if (rsp_rdata !== 32'h0) $display("[TB] FAIL zmask_rdata: got %h want 0", rsp_rdata); else passes++;
    finish_rsp();
    checks++;
    if ((rd_cnt - rd0) + (wr_cnt - wr0) !== 0)
      $display("[TB] FAIL zmask_mem_access: got %0d want 0", (rd_cnt - rd0) + (wr_cnt - wr0));
    else passes++;

    rsp_ready = 1'b0;
    send_req(1'b0, 4'h0, 6'h05, 32'h0);
    wait_rsp(n);
    checks++; if (rsp_rdata !== 32'hDEADBEEF) $display("[TB] FAIL bp_rdata: got %h want deadbeef", rsp_rdata); else passes++;
    held = rsp_rdata;
    rd0 = rd_cnt; wr0 = wr_cnt;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checks++; if (rsp_valid !== 1'b1) $display("[TB] FAIL bp_valid[%0d]: got %0b want 1", k, rsp_valid); else passes++;
      checks++; if (rsp_rdata !== held) $display("[TB] FAIL bp_stable[%0d]: got %h want %h", k, rsp_rdata, held); else passes++;
      checks++; if (req_ready !== 1'b0) $display("[TB] FAIL bp_req_ready[%0d]: got %0b want 0", k, req_ready); else passes++;
      checks++; if (mem_ce !== 1'b1) $display("[TB] FAIL bp_mem_ce[%0d]: got %0b want 1", k, mem_ce); else passes++;
    end
    checks++;
    if ((rd_cnt - rd0) + (wr_cnt - wr0) !== 0)
      $display("[TB] FAIL bp_mem_access: got %0d want 0", (rd_cnt - rd0) + (wr_cnt - wr0));
    else passes++;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) $display("[TB] FAIL bp_release_valid: got %0b want 0", rsp_valid); else passes++;
    checks++; if (req_ready !== 1'b1) $display("[TB] FAIL bp_release_ready: got %0b want 1", req_ready); else passes++;
  endtask

  task automatic test_reset_mid_op();
    int wr0, n;
    send_req(1'b1, 4'hF, 6'h20, 32'hCAFEF00D);
    wait_rsp(n);
    finish_rsp();
    wr0 = wr_cnt;
    send_req(1'b1, 4'b0011, 6'h20, 32'h00000000);
    checks++; if (mem_ce !== 1'b0) $display("[TB] FAIL mid_rd_ce: got %0b want 0", mem_ce); else passes++;
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (mem_ce !== 1'b1) $display("[TB] FAIL mid_async_ce: got %0b want 1", mem_ce); else passes++;
    checks++; if (req_ready !== 1'b1) $display("[TB] FAIL mid_idle_ready: got %0b want 1", req_ready); else passes++;
    checks++; if (rsp_valid !== 1'b0) $display("[TB] FAIL mid_rsp_valid: got %0b want 0", rsp_valid); else passes++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (wr_cnt - wr0 !== 0) $display("[TB] FAIL mid_no_write: got %0d writes want 0", wr_cnt - wr0); else passes++;
    checks++; if (sram[6'h20] !== 32'hCAFEF00D) $display("[TB] FAIL mid_word_kept: got %h want cafef00d", sram[6'h20]); else passes++;
    checks++; if (req_ready !== 1'b1) $display("[TB] FAIL mid_post_ready: got %0b want 1", req_ready); else passes++;
    send_req(1'b0, 4'h0, 6'h05, 32'h0);
    wait_rsp(n);
    checks++; if (n !== 2) $display("[TB] FAIL mid_load_latency: got %0d edges want 2", n); else passes++;
    checks++; if (rsp_rdata !== 32'hDEADBEEF) $display("[TB] FAIL mid_load_rdata: got %h want deadbeef", rsp_rdata); else passes++;
    finish_rsp();
  endtask

  initial begin
    checks = 0; passes = 0;
    cyc = 0; rd_cnt = 0; wr_cnt = 0; rd_cyc = 0; wr_cyc = 0;
    last_wr_addr = '0; last_wr_idat = '0;
    mem_odat = '0;
    for (int i = 0; i < 64; i++) sram[i] = '0;
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_be = 4'h0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1;
    test_reset();
    test_full_store_load();
    test_partial_rmw();
    test_zero_mask_backpressure();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/sram64x32_rmw_ctrl.md
# sram64x32_rmw_ctrl

Initiator-side controller for the 64x32 single-port SRAM wrapper built from four GF180 64x8 macros. It accepts word/byte-masked load and store requests from the core or cache pipeline over a valid/ready handshake and drives the wrapper's chip-enable, write-enable, address and data pins. The wrapper has no write mask, so partial stores run as read-modify-write. Load data and store acknowledgements return on a registered valid/ready response channel.

## Interface
Parameters:
- AW, 6, address width (64 words)
- DW, 32, data width (4 byte lanes)

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  clock; all state updates on the rising edge
  - rst_n  in  1  asynchronous, active-low reset
- Request channel:
  - req_valid  in  1  request present
  - req_ready  out  1  controller can accept a request
  - req_we  in  1  1 = store, 0 = load
  - req_be  in  4  byte enables for a store; bit i covers bits [8i+7:8i]; ignored for loads
  - req_addr  in  AW  word address
  - req_wdata  in  DW  store data
- Response channel:
  - rsp_valid  out  1  response present
  - rsp_ready  in  1  consumer accepts the response
  - rsp_rdata  out  DW  load data; 0 for stores
- Memory side (connects to the wrapper):
  - mem_ce  out  1  chip enable, active-low (0 = access); drives the macro CEN directly
  - mem_we  out  1  write enable, active-high
  - mem_addr  out  AW  word address
  - mem_idat  out  DW  write data
  - mem_odat  in  DW  read data; valid the cycle after a read access edge

## Operation
- Single outstanding transaction. No pipelining.
- Request acceptance:
  - req_ready = 1 only in IDLE.
  - A request is accepted on an edge where req_valid & req_ready.
  - req_addr, req_we, req_be and req_wdata are captured into internal registers at that edge.
- FSM states: IDLE, RD, CAP, WR, RESP.
- Transitions from IDLE on accept:
  - Load -> RD.
  - Store with be = 4'hF -> WR.
  - Store with be = 4'h0 -> RESP. No memory access.
  - Any other store -> RD (read-modify-write).
- RD:
  - mem_ce = 0, mem_we = 0, mem_addr = captured address.
  - Next state is CAP.
- CAP:
  - mem_ce = 1; mem_odat is valid in this cycle.
  - Load: rsp_rdata register <= mem_odat, then -> RESP.
  - Partial store: the data register is rewritten lane-wise. Lane i takes wdata when be[i] = 1, otherwise mem_odat lane i. Then -> WR.
- WR:
  - mem_ce = 0, mem_we = 1, mem_addr = captured address, mem_idat = data register.
  - Next state is RESP; rsp_rdata = 0.
- RESP:
  - rsp_valid = 1. rsp_valid and rsp_rdata stay stable until rsp_ready.
  - On rsp_valid & rsp_ready -> IDLE.
  - req_ready stays 0 in RESP; the next request is accepted no earlier than the cycle after the handshake.
- mem_ce = 1 and mem_we = 0 in every state except RD and WR. mem_addr and mem_idat are registered and hold their last value when idle.
- Reset values (asserted by rst_n = 0):
  - state IDLE, req_ready 1, rsp_valid 0, rsp_rdata 0
  - mem_ce 1, mem_we 0, mem_addr 0, mem_idat 0
- Reset asserted mid-transaction:
  - mem_ce goes to 1 immediately (asynchronously) and the transaction is dropped.
  - If reset lands during WR, the SRAM word is undefined; the bench does not check it.

## Timing
Let E0 be the accepting edge.
- Load:
  - RD is the cycle after E0; the SRAM samples at E1.
  - CAP follows E1; data is captured at E2.
  - rsp_valid is high from E2.
  - Minimum load-to-load period is 4 cycles with rsp_ready held at 1.
- Full store: WR after E0, write at E1, rsp_valid from E1.
- Partial store: RD, CAP, then WR at E2, write at E3, rsp_valid from E3.
- be = 0 store: rsp_valid from E0.
- Response back-pressure: rsp_ready = 0 holds RESP indefinitely. No memory activity occurs and mem_ce stays 1.
- All outputs come directly from flops. There is no combinational path from an input to any output.

## Test plan
- Reset and idle:
  - Hold rst_n = 0, then release.
  - Required: req_ready = 1, rsp_valid = 0, mem_ce = 1, mem_we = 0, mem_addr = 0.
  - Idle for 10 cycles: mem_ce stays 1.
- Full store then load:
  - Store addr 6'h05, data 32'hDEADBEEF, be 4'hF.
  - Required: exactly one mem_ce = 0 / mem_we = 1 cycle, and rsp_valid one edge after accept.
  - Then load addr 6'h05. Required: rsp_rdata = 32'hDEADBEEF, with rsp_valid two edges after accept.
- Partial store RMW:
  - Preload addr 6'h3F = 32'h11223344, then store 32'hAABBCCDD with be 4'b0101.
  - Required: one read cycle, then one write cycle with mem_idat = 32'h11BB33DD.
  - A subsequent load returns 32'h11BB33DD.
- Zero-mask store and back-pressure:
  - Store with be 4'h0: mem_ce never goes to 0, and rsp_valid is high the cycle after accept.
  - Load with rsp_ready = 0 for 5 cycles: rsp_valid and rsp_rdata stay stable, req_ready = 0 throughout, and mem_ce = 1.
- Reset mid-operation:
  - Assert rst_n = 0 during RD of a partial store.
  - Required: mem_ce = 1 in the same cycle; after release the FSM is in IDLE and no write occurs.
  - A following load of a different address completes normally.
